// File: rtl/diff_tx_serializer.sv
// Single-lane serializer driving the I/T pair of one OBUFTDS: frames each burst
// with a start marker and a trailer, and tristates the pad whenever idle.
module diff_tx_serializer #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int LEAD_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              buf_i,
   output logic              buf_t,
   output logic              busy
);

   localparam int BMAX = (DATA_W > LEAD_BITS) ? DATA_W : LEAD_BITS;
   localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

   localparam logic [CW-1:0] C_LAST    = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LEAD_LAST = BW'(LEAD_BITS - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEAD  = 2'd1,
      SHIFT = 2'd2,
      TRAIL = 2'd3
   } state_t;

   state_t            state, state_n;
   logic [CW-1:0]     ccnt, ccnt_n;
   logic [BW-1:0]     bcnt, bcnt_n;
   logic [DATA_W-1:0] sh, sh_n;
   logic [DATA_W-1:0] pend;
   logic              pend_v;
   logic              load;
   logic              accept;
   logic              bit_end;
   logic              buf_i_n;
   logic              buf_t_n;

   assign in_ready = !pend_v && !rst;
   assign accept   = in_valid && in_ready;
   assign bit_end  = (ccnt == C_LAST);

   always_comb begin
      state_n = state;
      ccnt_n  = ccnt;
      bcnt_n  = bcnt;
      sh_n    = sh;
      load    = 1'b0;
      case (state)
         IDLE: begin
            if (pend_v) begin
               load    = 1'b1;
               sh_n    = pend;
               ccnt_n  = '0;
               bcnt_n  = '0;
               state_n = LEAD;
            end
         end
         LEAD: begin
            if (bit_end) begin
               ccnt_n = '0;
               if (bcnt == LEAD_LAST) begin
                  bcnt_n  = '0;
                  state_n = SHIFT;
               end else begin
                  bcnt_n = bcnt + BW'(1);
               end
            end else begin
               ccnt_n = ccnt + CW'(1);
            end
         end
         SHIFT: begin
            if (bit_end) begin
               ccnt_n = '0;
               if (bcnt == DATA_LAST) begin
                  bcnt_n = '0;
                  // A waiting word continues the burst with no new marker.
                  if (pend_v) begin
                     load = 1'b1;
                     sh_n = pend;
                  end else begin
                     state_n = TRAIL;
                  end
               end else begin
                  bcnt_n = bcnt + BW'(1);
                  sh_n   = sh << 1;
               end
            end else begin
               ccnt_n = ccnt + CW'(1);
            end
         end
         TRAIL: begin
            if (bit_end) begin
               ccnt_n  = '0;
               state_n = IDLE;
            end else begin
               ccnt_n = ccnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Pad outputs follow the next state so they switch together with it.
   always_comb begin
      buf_t_n = (state_n == IDLE);
      buf_i_n = 1'b0;
      case (state_n)
         LEAD:    buf_i_n = 1'b1;
         SHIFT:   buf_i_n = sh_n[DATA_W-1];
         default: buf_i_n = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         ccnt   <= '0;
         bcnt   <= '0;
         sh     <= '0;
         pend_v <= 1'b0;
         buf_i  <= 1'b0;
         buf_t  <= 1'b1;
         busy   <= 1'b0;
      end else begin
         state <= state_n;
         ccnt  <= ccnt_n;
         bcnt  <= bcnt_n;
         sh    <= sh_n;
         buf_i <= buf_i_n;
         buf_t <= buf_t_n;
         busy  <= (state_n != IDLE);
         if (load) begin
            pend_v <= 1'b0;
         end else if (accept) begin
            pend_v <= 1'b1;
         end
      end
   end

   // Holding word: only qualified by pend_v, so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         pend <= in_data;
      end
   end

endmodule

// File: tb/tb_diff_tx_serializer.sv
// Directed bench for diff_tx_serializer: one CLKS_PER_BIT=2 instance and one
// CLKS_PER_BIT=1 instance, driven and sampled on the falling clock edge.
module tb_diff_tx_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b;
   logic       ready_a, ready_b;
   logic       bi_a, bi_b;
   logic       bt_a, bt_b;
   logic       busy_a, busy_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   diff_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(2), .LEAD_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .in_data(data_a), .in_valid(valid_a),
      .in_ready(ready_a), .buf_i(bi_a), .buf_t(bt_a), .busy(busy_a)
   );

   diff_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(1), .LEAD_BITS(1)) dut_b (
      .clk(clk), .rst(rst), .in_data(data_b), .in_valid(valid_b),
      .in_ready(ready_b), .buf_i(bi_b), .buf_t(bt_b), .busy(busy_b)
   );

   // Records buf_i for every cycle of the next buf_t-low run; len=-1 on timeout.
   task automatic capture(input bit sel, input int maxc, output logic [63:0] bits, output int len);
      bit   done;
      logic bt, bi;
      bits = '0;
      len  = 0;
      done = 1'b0;
      for (int c = 0; c < maxc && !done; c++) begin
         bt = sel ? bt_b : bt_a;
         bi = sel ? bi_b : bi_a;
         if (!bt) begin
            bits = {bits[62:0], bi};
            len++;
         end else if (len > 0) begin
            done = 1'b1;
         end
         if (!done) @(negedge clk);
      end
      if (!done) len = -1;
   endtask

   task automatic test_reset();
      bit bad;
      checks++; if (bt_a !== 1'b1) begin failures++; $display("FAIL rst_buf_t: got %b expected 1", bt_a); end
      checks++; if (bi_a !== 1'b0) begin failures++; $display("FAIL rst_buf_i: got %b expected 0", bi_a); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
      checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b expected 0", ready_a); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b expected 1", ready_a); end
      bad = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bt_a !== 1'b1 || busy_a !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) begin failures++; $display("FAIL rst_quiet: got activity expected none"); end
   endtask

   task automatic test_single();
      logic [63:0] bits;
      int          len;
      logic [19:0] expv;
      expv = 20'b11110011000011001100;
      @(negedge clk);
      checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL single_ready: got %b expected 1", ready_a); end
      valid_a = 1'b1;
      data_a  = 8'hA5;
      @(negedge clk);
      valid_a = 1'b0;
      data_a  = 8'h00;
      checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL single_pend: got %b expected 0", ready_a); end
      checks++; if (bt_a !== 1'b1) begin failures++; $display("FAIL single_latency: got %b expected 1", bt_a); end
      capture(1'b0, 60, bits, len);
      checks++; if (len !== 20) begin failures++; $display("FAIL single_len: got %0d expected 20", len); end
      checks++; if (bits !== {44'b0, expv}) begin failures++; $display("FAIL single_bits: got %h expected %h", bits, expv); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %b expected 0", busy_a); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] bits;
      int          len;
      logic [35:0] expv;
      expv = {2'b11, 16'b1100110000110011, 16'b0000111111110000, 2'b00};
      @(negedge clk);
      fork
         capture(1'b0, 100, bits, len);
         begin
            valid_a = 1'b1;
            data_a  = 8'hA5;
            @(negedge clk);
            data_a = 8'h3C;
            checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL b2b_pend_full: got %b expected 0", ready_a); end
            @(negedge clk);
            checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_load: got %b expected 1", ready_a); end
            @(negedge clk);
            valid_a = 1'b0;
            checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL b2b_second_accept: got %b expected 0", ready_a); end
         end
      join
      checks++; if (len !== 36) begin failures++; $display("FAIL b2b_len: got %0d expected 36", len); end
      checks++; if (bits !== {28'b0, expv}) begin failures++; $display("FAIL b2b_bits: got %h expected %h", bits, expv); end
   endtask

   task automatic test_late_word();
      logic [43:0] tr_t, tr_i, exp_t, exp_i;
      logic [19:0] w;
      w     = 20'b11110000000000001100;
      exp_t = {2'b11, 20'b0, 1'b1, 20'b0, 1'b1};
      exp_i = {2'b00, w, 1'b0, w, 1'b0};
      tr_t  = '0;
      tr_i  = '0;
      @(negedge clk);
      for (int i = 0; i < 44; i++) begin
         tr_t = {tr_t[42:0], bt_a};
         tr_i = {tr_i[42:0], bi_a};
         if (i == 20) begin
            checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL late_ready_trail: got %b expected 1", ready_a); end
         end
         valid_a = (i == 0 || i == 20);
         data_a  = 8'h81;
         @(negedge clk);
      end
      checks++; if (tr_t !== exp_t) begin failures++; $display("FAIL late_buf_t: got %h expected %h", tr_t, exp_t); end
      checks++; if (tr_i !== exp_i) begin failures++; $display("FAIL late_buf_i: got %h expected %h", tr_i, exp_i); end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_q[$];
      bit         rx[$];
      int         acc;
      logic [7:0] word;
      acc = 0;
      @(negedge clk);
      fork
         begin
            valid_a = 1'b1;
            for (int c = 0; c < 400 && acc < 16; c++) begin
               data_a = 8'($urandom);
               if (ready_a) begin
                  exp_q.push_back(data_a);
                  acc++;
               end
               @(negedge clk);
            end
            valid_a = 1'b0;
         end
         begin
            bit started, ended;
            started = 1'b0;
            ended   = 1'b0;
            for (int c = 0; c < 700 && !ended; c++) begin
               if (!bt_a) begin
                  rx.push_back(bi_a);
                  started = 1'b1;
               end else if (started) begin
                  ended = 1'b1;
               end
               if (!ended) @(negedge clk);
            end
         end
      join
      checks++; if (acc !== 16) begin failures++; $display("FAIL bp_accepts: got %0d expected 16", acc); end
      checks++; if (rx.size() !== 260) begin failures++; $display("FAIL bp_len: got %0d expected 260", rx.size()); end
      if (rx.size() >= 260 && exp_q.size() == 16) begin
         for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 8; b++) word[7-b] = rx[2 + 16*w + 2*b];
            checks++; if (word !== exp_q[w]) begin failures++; $display("FAIL bp_word%0d: got %h expected %h", w, word, exp_q[w]); end
         end
      end
   endtask

   task automatic test_cpb1();
      logic [63:0] bits;
      int          len;
      logic [9:0]  expv;
      expv = 10'b1111111110;
      @(negedge clk);
      checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL cpb1_ready: got %b expected 1", ready_b); end
      valid_b = 1'b1;
      data_b  = 8'hFF;
      fork
         capture(1'b1, 40, bits, len);
         begin
            @(negedge clk);
            valid_b = 1'b0;
         end
      join
      checks++; if (len !== 10) begin failures++; $display("FAIL cpb1_len: got %0d expected 10", len); end
      checks++; if (bits !== {54'b0, expv}) begin failures++; $display("FAIL cpb1_bits: got %h expected %h", bits, expv); end
   endtask

   task automatic test_reset_mid_burst();
      bit bad;
      @(negedge clk);
      valid_a = 1'b1;
      data_a  = 8'hA5;
      @(negedge clk);
      valid_a = 1'b0;
      repeat (5) @(negedge clk);
      valid_a = 1'b1;
      data_a  = 8'h3C;
      @(negedge clk);
      valid_a = 1'b0;
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b expected 1", busy_a); end
      checks++; if (bt_a !== 1'b0) begin failures++; $display("FAIL mid_driving: got %b expected 0", bt_a); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bt_a !== 1'b1) begin failures++; $display("FAIL mid_rst_buf_t: got %b expected 1", bt_a); end
      checks++; if (bi_a !== 1'b0) begin failures++; $display("FAIL mid_rst_buf_i: got %b expected 0", bi_a); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL mid_rst_busy: got %b expected 0", busy_a); end
      checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL mid_rst_ready: got %b expected 0", ready_a); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL mid_release_ready: got %b expected 1", ready_a); end
      bad = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bt_a !== 1'b1 || busy_a !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) begin failures++; $display("FAIL mid_discard: got activity expected none"); end
   endtask

   initial begin
      rst     = 1'b1;
      data_a  = '0;
      data_b  = '0;
      valid_a = 1'b0;
      valid_b = 1'b0;
      #2;
      test_reset();
      test_single();
      test_back_to_back();
      test_late_word();
      test_backpressure();
      test_cpb1();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/diff_tx_serializer.md
# diff_tx_serializer

Single-lane serial transmitter that produces the data (`buf_i`) and tristate-control (`buf_t`) pair feeding one OBUFTDS differential output buffer. It accepts parallel words over a valid/ready handshake, frames each burst with a start marker and trailer, and tristates the pad (`buf_t`=1) whenever idle. One instance per differential pair; instantiate N times for N lanes.

## Interface
- `DATA_W`, 8, word width in bits (>=1); sent MSB first.
- `CLKS_PER_BIT`, 4, clock cycles each bit is held on `buf_i` (>=1).
- `LEAD_BITS`, 1, length of the start marker in bit-times (>=1).

- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_data`  input  DATA_W  word to transmit.
- `in_valid`  input  1  `in_data` valid.
- `in_ready`  output  1  block can accept a word this cycle.
- `buf_i`  output  1  data to OBUFTDS `I`; registered.
- `buf_t`  output  1  tristate to OBUFTDS `T` (1 = pad high-Z); registered.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- Storage: one pending register (`pend`, `pend_v`) plus shift register `sh`. `in_ready` = !`pend_v` && !`rst` (combinational). Transfer when `in_valid` && `in_ready` at an edge: `pend`<=`in_data`, `pend_v`<=1.
- Accept and pend->sh load never coincide (accept needs `pend_v`=0, load needs `pend_v`=1).
- Counters: `ccnt` 0..CLKS_PER_BIT-1 (bit-time divider), `bcnt` 0..max(DATA_W,LEAD_BITS)-1.
- States:
  - IDLE: `buf_t`=1, `buf_i`=0. If `pend_v`: `sh`<=`pend`, `pend_v`<=0, counters cleared, -> LEAD.
  - LEAD: `buf_t`=0, `buf_i`=1 for LEAD_BITS*CLKS_PER_BIT cycles, -> SHIFT.
  - SHIFT: `buf_t`=0, `buf_i`=`sh[DATA_W-1]`; each bit held CLKS_PER_BIT cycles, then `sh` shifts left. At final cycle of bit DATA_W-1: if `pend_v`, load `sh`<=`pend`, clear `pend_v`, stay SHIFT with counters cleared (back-to-back, no marker); else -> TRAIL.
  - TRAIL: `buf_t`=0, `buf_i`=0 for CLKS_PER_BIT cycles, -> IDLE.
- `buf_i`/`buf_t` are registered from next-state values so they change in the same cycle the state does (no extra output lag).
- `busy` = (state != IDLE), registered with state.

## Timing
- Reset (async, immediate): state IDLE, `buf_t`=1, `buf_i`=0, `busy`=0, `pend_v`=0, `sh`=0, counters 0; `in_ready`=0 while `rst` high, 1 in first cycle after release.
- Reset mid-burst: pad tristates immediately; pending and in-flight words discarded; no trailer emitted.
- Latency: word accepted at edge k -> `pend_v`=1 after k; at edge k+1 IDLE loads, `buf_t` falls and `buf_i` rises after edge k+1.
- Single word: `buf_t` low for exactly (LEAD_BITS + DATA_W + 1)*CLKS_PER_BIT cycles.
- Burst of W words, each accepted before the previous word's last bit ends: `buf_t` low (LEAD_BITS + W*DATA_W + 1)*CLKS_PER_BIT cycles, contiguous, one marker, one trailer.
- Word arriving in TRAIL: trailer completes, IDLE for 1 cycle, then new LEAD.
- `in_ready` returns high the cycle after pend->sh load; producer may hold `in_valid` high continuously.
- `in_data` is sampled only on accept; changes while `in_ready`=0 are ignored.
- CLKS_PER_BIT=1: all bit-times one cycle; no special casing.

## Test plan
- Reset: assert `rst` mid-SHIFT -> same cycle `buf_t`=1, `buf_i`=0, `busy`=0; after release `in_ready`=1, no output activity without input.
- Single word (DATA_W=8, CLKS_PER_BIT=2, LEAD_BITS=1), send 0xA5 -> `buf_t` low 20 cycles; `buf_i` = 11, 11 00 11 00 00 11 00 11, 00; then `buf_t`=1.
- Back-to-back: 0xA5 then 0x3C with `in_valid` held -> `buf_t` low 36 contiguous cycles, `buf_i` = 11, A5 bits, 3C bits (00 00 11 11 11 11 00 00), 00; second accept occurs one cycle after first load.
- Late word: send 0x81 after previous burst reaches TRAIL -> full trailer, 1 IDLE cycle (`buf_t`=1), then fresh LEAD.
- Backpressure: hold `in_valid` with changing `in_data` while `in_ready`=0 -> only values present on accepting edges are transmitted, none lost or duplicated over 16 random words.
- CLKS_PER_BIT=1, 0xFF -> `buf_t` low 10 cycles, `buf_i` high 9 cycles then low 1.
